// File: rtl/accel_mmio_ctrl.sv
// Register front end for the cipher co-processor: key/data registers, start/ready launch,
// result capture, busy/done/error status and a core watchdog.
module accel_mmio_ctrl #(
  parameter int          KEY_WORDS   = 4,
  parameter int          BLOCK_WORDS = 4,
  parameter int          TIMEOUT_CYC = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              addr_i,
  input  logic                     wr_en_i,
  input  logic                     select_i,
  input  logic [31:0]              data_i,
  output logic [31:0]              data_o,
  output logic                     core_start_o,
  input  logic                     core_ready_i,
  output logic                     core_mode_o,
  output logic [32*KEY_WORDS-1:0]  core_key_o,
  output logic [32*BLOCK_WORDS-1:0] core_din_o,
  input  logic                     core_done_i,
  input  logic [32*BLOCK_WORDS-1:0] core_result_i,
  output logic                     core_abort_o
);
  localparam int            TW       = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [31:0]   r_key  [KEY_WORDS];
  logic [31:0]   r_din  [BLOCK_WORDS];
  logic [31:0]   r_dout [BLOCK_WORDS];
  logic          r_mode;
  logic          r_start;
  logic          r_abort;
  logic          r_done;
  logic          r_err_tmo;
  logic          r_err_wr;

  logic [29:0] w_word;
  logic [1:0]  w_unused_addr;
  logic        w_wr;
  logic        w_busy;
  logic        w_hit_key;
  logic        w_hit_din;
  logic        w_hit_ctrl;
  logic        w_wr_err;
  logic        w_ack;
  logic        w_go;
  logic [31:0] w_status;

  // Word index relative to the block base; addresses below the base wrap to unmapped.
  assign w_word        = addr_i[31:2] - BASE_ADDR[31:2];
  assign w_unused_addr = addr_i[1:0];

  assign w_wr       = select_i && wr_en_i;
  assign w_busy     = (r_state != ST_IDLE);
  assign w_hit_key  = (w_word < 30'(KEY_WORDS));
  assign w_hit_din  = (w_word >= 30'd4) && (w_word < 30'(4 + BLOCK_WORDS));
  assign w_hit_ctrl = (w_word == 30'd8);
  assign w_wr_err   = w_wr && w_busy && (w_hit_key || w_hit_din || (w_hit_ctrl && data_i[0]));
  assign w_ack      = w_wr && w_hit_ctrl && data_i[2];
  assign w_go       = w_wr && w_hit_ctrl && data_i[0] && !w_busy;
  assign w_status   = {28'd0, r_err_wr, r_err_tmo, r_done, w_busy};

  assign core_start_o = r_start;
  assign core_abort_o = r_abort;
  assign core_mode_o  = r_mode;

  genvar gi;
  generate
    for (gi = 0; gi < KEY_WORDS; gi++) begin : g_key
      assign core_key_o[32*gi +: 32] = r_key[gi];
    end
    for (gi = 0; gi < BLOCK_WORDS; gi++) begin : g_din
      assign core_din_o[32*gi +: 32] = r_din[gi];
    end
  endgenerate

  // Key and input block are frozen while the core owns them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < KEY_WORDS; k++) r_key[k] <= '0;
      for (int k = 0; k < BLOCK_WORDS; k++) r_din[k] <= '0;
    end else if (w_wr && !w_busy) begin
      for (int k = 0; k < KEY_WORDS; k++)
        if (w_word == 30'(k)) r_key[k] <= data_i;
      for (int k = 0; k < BLOCK_WORDS; k++)
        if (w_word == 30'(4 + k)) r_din[k] <= data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      r_mode    <= 1'b0;
      r_start   <= 1'b0;
      r_abort   <= 1'b0;
      r_done    <= 1'b0;
      r_err_tmo <= 1'b0;
      r_err_wr  <= 1'b0;
      for (int k = 0; k < BLOCK_WORDS; k++) r_dout[k] <= '0;
    end else begin
      r_abort <= 1'b0;
      // ACK is applied before any error raised by the same write.
      if (w_ack) begin
        r_done    <= 1'b0;
        r_err_tmo <= 1'b0;
        r_err_wr  <= 1'b0;
      end
      if (w_wr_err) r_err_wr <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (w_go) begin
            r_state   <= ST_ISSUE;
            r_mode    <= data_i[1];
            r_start   <= 1'b1;
            r_done    <= 1'b0;
            r_err_tmo <= 1'b0;
            r_err_wr  <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (core_ready_i) begin
            r_start <= 1'b0;
            r_timer <= '0;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (core_done_i) begin
            for (int k = 0; k < BLOCK_WORDS; k++) r_dout[k] <= core_result_i[32*k +: 32];
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else if (r_timer == TMO_LAST) begin
            r_abort   <= 1'b1;
            r_err_tmo <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    data_o = 32'd0;
    if (select_i && !wr_en_i) begin
      for (int k = 0; k < KEY_WORDS; k++)
        if (w_word == 30'(k)) data_o = r_key[k];
      for (int k = 0; k < BLOCK_WORDS; k++)
        if (w_word == 30'(4 + k)) data_o = r_din[k];
      if (w_word == 30'd9) data_o = w_status;
      for (int k = 0; k < BLOCK_WORDS; k++)
        if (w_word == 30'(12 + k)) data_o = r_dout[k];
    end
  end
endmodule
